fifo_writectrl: RTL

//  Write-side controller for the dual-FIFO input port (regular FIFO + priority FIFO).

---
 rtl/fifo_writectrl_if.sv | 40 ++++
 rtl/fifo_writectrl.sv | 98 +++++++++
 2 files changed

// File: rtl/fifo_writectrl_if.sv
// Handshake bundle between the upstream flit source / read controller and the
// dual-FIFO write controller, plus debug visibility of the FSM and occupancy.
interface fifo_writectrl_if #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
);
  // Valid/ready: a flit transfers on a cycle where flit_valid & ready are both
  // high; a stalled flit (ready low) must be held stable until accepted.
  logic          flit_valid;
  logic [2:0]    head;
  logic          regularFIFO_read;
  logic          priorityFIFO_read;
  logic          ready;
  logic          regularFIFO_write;
  logic          priorityFIFO_write;
  logic          regularFIFO_empty;
  logic          priorityFIFO_empty;
  logic          regularFIFO_full;
  logic          priorityFIFO_full;
  logic          proto_err;
  logic [1:0]    state_dbg;
  logic [CW-1:0] regular_cnt;
  logic [CW-1:0] priority_cnt;

  modport master (
    output flit_valid, head, regularFIFO_read, priorityFIFO_read,
    input  ready, regularFIFO_write, priorityFIFO_write,
           regularFIFO_empty, priorityFIFO_empty,
           regularFIFO_full, priorityFIFO_full,
           proto_err, state_dbg, regular_cnt, priority_cnt
  );

  modport slave (
    input  flit_valid, head, regularFIFO_read, priorityFIFO_read,
    output ready, regularFIFO_write, priorityFIFO_write,
           regularFIFO_empty, priorityFIFO_empty,
           regularFIFO_full, priorityFIFO_full,
           proto_err, state_dbg, regular_cnt, priority_cnt
  );
endinterface

// File: rtl/fifo_writectrl.sv
// Write-side controller for a dual-FIFO input port: steers each packet into the
// regular or priority FIFO by head code and tracks occupancy of both FIFOs.
module fifo_writectrl #(
  parameter int DEPTH = 8
) (
  input logic             clk,
  input logic             rst,
  fifo_writectrl_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REG_PKT = 2'd1;
  localparam logic [1:0] PRI_PKT = 2'd2;

  localparam logic [2:0] H_REG_HEAD   = 3'b100;
  localparam logic [2:0] H_PRI_HEAD   = 3'b110;
  localparam logic [2:0] H_REG_SINGLE = 3'b101;
  localparam logic [2:0] H_PRI_SINGLE = 3'b111;
  localparam logic [2:0] H_BODY       = 3'b010;
  localparam logic [2:0] H_TAIL       = 3'b001;

  logic [1:0]    state, state_next;
  logic [CW-1:0] reg_cnt, pri_cnt;
  logic          drop, tgt_pri;
  logic          reg_full, pri_full, tgt_full;
  logic          accept, reg_wr, pri_wr;
  logic          reg_rd_eff, pri_rd_eff;
  logic          proto_err_q;

  // Decode: which FIFO the flit targets, whether it is dropped, and next state.
  always_comb begin
    drop       = 1'b1;
    tgt_pri    = 1'b0;
    state_next = state;
    case (state)
      IDLE: begin
        case (bus.head)
          H_REG_HEAD:   begin drop = 1'b0; tgt_pri = 1'b0; state_next = REG_PKT; end
          H_PRI_HEAD:   begin drop = 1'b0; tgt_pri = 1'b1; state_next = PRI_PKT; end
          H_REG_SINGLE: begin drop = 1'b0; tgt_pri = 1'b0; end
          H_PRI_SINGLE: begin drop = 1'b0; tgt_pri = 1'b1; end
          default:      drop = 1'b1;
        endcase
      end
      REG_PKT, PRI_PKT: begin
        tgt_pri = (state == PRI_PKT);
        case (bus.head)
          H_BODY:  drop = 1'b0;
          H_TAIL:  begin drop = 1'b0; state_next = IDLE; end
          default: drop = 1'b1;
        endcase
      end
      default: begin
        drop       = 1'b1;
        state_next = IDLE;
      end
    endcase
  end

  assign reg_full = (reg_cnt == CW'(DEPTH));
  assign pri_full = (pri_cnt == CW'(DEPTH));
  assign tgt_full = tgt_pri ? pri_full : reg_full;

  // Dropped flits are always consumed; writable flits wait for room.
  assign bus.ready = drop | ~tgt_full;
  assign accept    = bus.flit_valid & bus.ready;
  assign reg_wr    = accept & ~drop & ~tgt_pri;
  assign pri_wr    = accept & ~drop & tgt_pri;

  assign reg_rd_eff = bus.regularFIFO_read  & (reg_cnt != '0);
  assign pri_rd_eff = bus.priorityFIFO_read & (pri_cnt != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      reg_cnt     <= '0;
      pri_cnt     <= '0;
      proto_err_q <= 1'b0;
    end else begin
      if (accept) state <= state_next;
      reg_cnt     <= reg_cnt + CW'(reg_wr) - CW'(reg_rd_eff);
      pri_cnt     <= pri_cnt + CW'(pri_wr) - CW'(pri_rd_eff);
      proto_err_q <= accept & drop;
    end
  end

  assign bus.regularFIFO_write  = reg_wr;
  assign bus.priorityFIFO_write = pri_wr;
  assign bus.regularFIFO_empty  = (reg_cnt == '0);
  assign bus.priorityFIFO_empty = (pri_cnt == '0);
  assign bus.regularFIFO_full   = reg_full;
  assign bus.priorityFIFO_full  = pri_full;
  assign bus.proto_err          = proto_err_q;
  assign bus.state_dbg          = state;
  assign bus.regular_cnt        = reg_cnt;
  assign bus.priority_cnt       = pri_cnt;
endmodule
